// File: rtl/nes_bus_controller_pkg.sv
// Shared types and address map for the NES bus controller.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_SRAM,
      S_REG,
      S_DONE
   } bus_state_t;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_PPU,
      REGION_IO,
      REGION_CART
   } region_t;

   localparam logic [31:0] PPU_BASE  = 32'h2000;
   localparam logic [31:0] IO_BASE   = 32'h4000;
   localparam logic [31:0] CART_BASE = 32'h4020;

   function automatic region_t decode_region(input logic [31:0] a);
      if (a < PPU_BASE)       return REGION_RAM;
      else if (a < IO_BASE)   return REGION_PPU;
      else if (a < CART_BASE) return REGION_IO;
      else                    return REGION_CART;
   endfunction

endpackage

// File: rtl/nes_bus_controller_if.sv
// Multi-master request/acknowledge bundle.
interface nes_bus_controller_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 16
);
   logic [NUM_PORTS-1:0]                 req;
   logic [NUM_PORTS-1:0]                 we;
   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
   logic [NUM_PORTS-1:0][7:0]            wdata;
   logic [NUM_PORTS-1:0]                 ack;
   logic [7:0]                           rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/nes_bus_controller_arbiter.sv
// Fixed or rotating priority arbiter; pointer moves past each grantee.
module nes_bus_arbiter #(
   parameter int NUM_PORTS   = 2,
   parameter bit ROUND_ROBIN = 1'b0,
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [NUM_PORTS-1:0] req_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PW-1:0]        idx_o
);
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] base;

   assign base = ROUND_ROBIN ? ptr_q : '0;

   always_comb begin
      logic hit;
      int   j;
      hit   = 1'b0;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         j = (int'(base) + i) % NUM_PORTS;
         if (!hit && req_i[j]) begin
            hit      = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         ptr_q <= '0;
      else if (en_i && |req_i)
         ptr_q <= PW'((int'(idx_o) + 1) % NUM_PORTS);
   end
endmodule

// File: rtl/nes_bus_controller.sv
// Arbitrates masters onto board SRAM, PPU registers and APU/IO registers,
// modelling the open-bus latch for partially driven IO reads.
module nes_bus_controller
   import nes_bus_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int ADDR_WIDTH      = 16,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int SRAM_WAIT       = 1,
   parameter int ROUND_ROBIN     = 0,
   parameter int RAM_MIRROR_BITS = 11
) (
   input  logic                       cpu_clock,
   input  logic                       reset,
   nes_bus_controller_if.slave        bus,
   input  logic [31:0][7:0]           io_regs,
   input  logic [31:0][7:0]           io_regs_active,
   output logic                       io_write,
   output logic [4:0]                 io_index,
   output logic [7:0]                 io_wdata,
   output logic                       ppu_sel,
   output logic                       ppu_we,
   output logic [2:0]                 ppu_reg,
   output logic [7:0]                 ppu_wdata,
   input  logic [7:0]                 ppu_rdata,
   output logic [ADDR_WIDTH-1:0]      mapper_input_address,
   input  logic [SRAM_ADDR_WIDTH-1:0] mapper_output_address,
   output logic                       sram_oe_n,
   output logic                       sram_we_n,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [7:0]                 sram_wdata,
   output logic                       sram_data_oe,
   input  logic [7:0]                 sram_rdata
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   bus_state_t                 state_q;
   region_t                    region_q, region_d;
   logic [NUM_PORTS-1:0]       gsel_q, gnt, ack_q;
   logic [PW-1:0]              gidx;
   logic [ADDR_WIDTH-1:0]      gaddr_q;
   logic                       gwe_q;
   logic [7:0]                 gwdata_q, rdata_q, open_q;
   logic [7:0]                 io_rd_d, rd_d, act;
   logic [2:0]                 cnt_q;
   logic                       io_write_q, ppu_sel_q, ppu_we_q;
   logic [4:0]                 io_index_q;
   logic [7:0]                 io_wdata_q, ppu_wdata_q, sram_wdata_q;
   logic [2:0]                 ppu_reg_q;
   logic                       sram_oe_n_q, sram_we_n_q, sram_data_oe_q;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, ram_addr;

   nes_bus_arbiter #(
      .NUM_PORTS   (NUM_PORTS),
      .ROUND_ROBIN (ROUND_ROBIN != 0)
   ) u_arb (
      .clk_i (cpu_clock),
      .rst_i (reset),
      .en_i  (state_q == S_IDLE),
      .req_i (bus.req),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   assign region_d = decode_region(32'(gaddr_q));
   assign ram_addr = SRAM_ADDR_WIDTH'(gaddr_q[RAM_MIRROR_BITS-1:0]);
   assign act      = io_regs_active[gaddr_q[4:0]];
   // Undriven IO bits float to whatever the bus last carried
   assign io_rd_d  = (act & io_regs[gaddr_q[4:0]]) | (~act & open_q);
   assign rd_d     = (region_q == REGION_PPU && !gwe_q) ? ppu_rdata : rdata_q;

   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         region_q       <= REGION_RAM;
         gsel_q         <= '0;
         gaddr_q        <= '0;
         gwe_q          <= 1'b0;
         gwdata_q       <= '0;
         cnt_q          <= '0;
         ack_q          <= '0;
         rdata_q        <= '0;
         open_q         <= '0;
         io_write_q     <= 1'b0;
         io_index_q     <= '0;
         io_wdata_q     <= '0;
         ppu_sel_q      <= 1'b0;
         ppu_we_q       <= 1'b0;
         ppu_reg_q      <= '0;
         ppu_wdata_q    <= '0;
         sram_oe_n_q    <= 1'b1;
         sram_we_n_q    <= 1'b1;
         sram_addr_q    <= '0;
         sram_wdata_q   <= '0;
         sram_data_oe_q <= 1'b0;
      end else begin
         ack_q      <= '0;
         io_write_q <= 1'b0;
         ppu_sel_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: if (|bus.req) begin
               gsel_q   <= gnt;
               gaddr_q  <= bus.addr[gidx];
               gwe_q    <= bus.we[gidx];
               gwdata_q <= bus.wdata[gidx];
               state_q  <= S_GRANT;
            end
            S_GRANT: begin
               region_q <= region_d;
               unique case (region_d)
                  REGION_PPU: begin
                     ppu_sel_q   <= 1'b1;
                     ppu_we_q    <= gwe_q;
                     ppu_reg_q   <= gaddr_q[2:0];
                     ppu_wdata_q <= gwdata_q;
                     state_q     <= S_REG;
                  end
                  REGION_IO: begin
                     io_write_q <= gwe_q;
                     io_index_q <= gaddr_q[4:0];
                     io_wdata_q <= gwdata_q;
                     state_q    <= S_REG;
                  end
                  default: begin
                     sram_addr_q    <= (region_d == REGION_RAM) ?
                                       ram_addr : mapper_output_address;
                     sram_we_n_q    <= ~gwe_q;
                     sram_oe_n_q    <= gwe_q;
                     sram_data_oe_q <= gwe_q;
                     sram_wdata_q   <= gwdata_q;
                     cnt_q          <= 3'(SRAM_WAIT);
                     state_q        <= S_SRAM;
                  end
               endcase
            end
            S_SRAM: begin
               if (cnt_q == 3'd0) begin
                  sram_oe_n_q    <= 1'b1;
                  sram_we_n_q    <= 1'b1;
                  sram_data_oe_q <= 1'b0;
                  if (!gwe_q) rdata_q <= sram_rdata;
                  ack_q   <= gsel_q;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_REG: begin
               if (region_q == REGION_IO && !gwe_q) rdata_q <= io_rd_d;
               ack_q   <= gsel_q;
               state_q <= S_DONE;
            end
            S_DONE: begin
               rdata_q <= rd_d;
               open_q  <= gwe_q ? gwdata_q : rd_d;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ack              = ack_q;
   assign bus.rdata            = (state_q == S_DONE) ? rd_d : rdata_q;
   assign io_write             = io_write_q;
   assign io_index             = io_index_q;
   assign io_wdata             = io_wdata_q;
   assign ppu_sel              = ppu_sel_q;
   assign ppu_we               = ppu_we_q;
   assign ppu_reg              = ppu_reg_q;
   assign ppu_wdata            = ppu_wdata_q;
   assign mapper_input_address = gaddr_q;
   assign sram_oe_n            = sram_oe_n_q;
   assign sram_we_n            = sram_we_n_q;
   assign sram_addr            = sram_addr_q;
   assign sram_wdata           = sram_wdata_q;
   assign sram_data_oe         = sram_data_oe_q;
endmodule

// File: tb/tb_nes_bus_controller.sv
// Randomized bench for nes_bus_controller against a behavioural bus model.
module tb_nes_bus_controller;
   localparam int W = 1;

   logic cpu_clock = 1'b0;
   logic reset;
   always #5 cpu_clock = ~cpu_clock;

   nes_bus_controller_if #(.NUM_PORTS(2), .ADDR_WIDTH(16)) bus ();
   nes_bus_controller_if #(.NUM_PORTS(2), .ADDR_WIDTH(16)) bus_fp ();

   logic [31:0][7:0] io_regs, io_act;
   logic        io_write, ppu_sel, ppu_we, sram_oe_n, sram_we_n, sram_data_oe;
   logic [4:0]  io_index;
   logic [7:0]  io_wdata, ppu_wdata, sram_wdata, sram_rdata;
   logic [7:0]  ppu_rdata = 8'h00;
   logic [2:0]  ppu_reg;
   logic [15:0] map_in;
   logic [19:0] map_out, sram_addr;

   logic        f_io_write, f_ppu_sel, f_ppu_we, f_oe_n, f_we_n, f_doe;
   logic [4:0]  f_io_index;
   logic [7:0]  f_io_wdata, f_ppu_wdata, f_sram_wdata;
   logic [2:0]  f_ppu_reg;
   logic [15:0] f_map_in;
   logic [19:0] f_map_out, f_sram_addr;

   assign map_out   = 20'(map_in) + 20'hC000;
   assign f_map_out = 20'(f_map_in) + 20'hC000;

   nes_bus_controller #(.SRAM_WAIT(W), .ROUND_ROBIN(1)) dut (
      .cpu_clock(cpu_clock), .reset(reset), .bus(bus),
      .io_regs(io_regs), .io_regs_active(io_act),
      .io_write(io_write), .io_index(io_index), .io_wdata(io_wdata),
      .ppu_sel(ppu_sel), .ppu_we(ppu_we), .ppu_reg(ppu_reg),
      .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
      .mapper_input_address(map_in), .mapper_output_address(map_out),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
      .sram_rdata(sram_rdata));

   nes_bus_controller #(.SRAM_WAIT(W), .ROUND_ROBIN(0)) dut_fp (
      .cpu_clock(cpu_clock), .reset(reset), .bus(bus_fp),
      .io_regs(io_regs), .io_regs_active(io_act),
      .io_write(f_io_write), .io_index(f_io_index), .io_wdata(f_io_wdata),
      .ppu_sel(f_ppu_sel), .ppu_we(f_ppu_we), .ppu_reg(f_ppu_reg),
      .ppu_wdata(f_ppu_wdata), .ppu_rdata(ppu_rdata),
      .mapper_input_address(f_map_in), .mapper_output_address(f_map_out),
      .sram_oe_n(f_oe_n), .sram_we_n(f_we_n), .sram_addr(f_sram_addr),
      .sram_wdata(f_sram_wdata), .sram_data_oe(f_doe),
      .sram_rdata(sram_rdata));

   // Board devices: SRAM array and PPU register file
   logic [7:0] dev_mem [0:(1<<20)-1];
   logic [7:0] ppu_val [0:7];
   assign sram_rdata = dev_mem[sram_addr];
   always @(posedge cpu_clock)
      if (!sram_we_n && sram_data_oe) dev_mem[sram_addr] <= sram_wdata;
   always @(posedge cpu_clock)
      if (ppu_sel) ppu_rdata <= ppu_val[ppu_reg];

   int io_q[$];
   int ppu_q[$];
   logic [19:0] last_sa;
   always @(negedge cpu_clock) begin
      if (io_write) io_q.push_back(int'({io_index, io_wdata}));
      if (ppu_sel) ppu_q.push_back(int'({ppu_reg, ppu_we, ppu_wdata}));
      if (!sram_oe_n || !sram_we_n) last_sa = sram_addr;
   end

   // Reference model state
   logic [7:0] ref_mem [int];
   logic [7:0] ob;
   int rr_next;
   int n_chk = 0;
   int n_fail = 0;

   function automatic logic [7:0] pat(input int a);
      return 8'(a ^ (a >> 8) ^ (a >> 16)) ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : pat(a);
   endfunction

   function automatic int region_of(input logic [15:0] a);
      if (a < 16'h2000) return 0;
      if (a < 16'h4000) return 1;
      if (a < 16'h4020) return 2;
      return 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic txn(input int p, input bit w, input logic [15:0] a,
                      input logic [7:0] d, output logic [7:0] rd,
                      output int lat, output bit ok);
      @(negedge cpu_clock);
      bus.req[p] = 1'b1;
      bus.we[p] = w;
      bus.addr[p] = a;
      bus.wdata[p] = d;
      ok = 1'b0;
      lat = 0;
      rd = 8'h00;
      for (int k = 1; k <= 40 && !ok; k++) begin
         @(negedge cpu_clock);
         if (bus.ack != 2'b00) begin
            ok = 1'b1;
            lat = k + 1;
            rd = bus.rdata;
            chk("ack_onehot", 32'(bus.ack), 32'(1 << p));
         end
      end
      bus.req[p] = 1'b0;
   endtask

   task automatic do_op(input int p, input bit w, input logic [15:0] a,
                        input logic [7:0] d, output logic [7:0] rd);
      int lat, rg, e, idx, sa;
      bit ok;
      logic [7:0] exp;
      rg = region_of(a);
      io_q.delete();
      ppu_q.delete();
      last_sa = 'x;
      txn(p, w, a, d, rd, lat, ok);
      rr_next = (p + 1) % 2;
      chk("ack_seen", 32'(ok), 32'd1);
      if (!ok) return;
      chk("latency", lat, (rg == 0 || rg == 3) ? 4 + W : 4);
      if (rg == 0 || rg == 3) begin
         sa = (rg == 0) ? int'(a) % 2048 : int'(a) + 'hC000;
         chk("sram_addr", 32'(last_sa), sa);
         if (w) begin
            ref_mem[sa] = d;
            ob = d;
            chk("sram_wr", 32'(dev_mem[sa]), 32'(d));
         end else begin
            exp = ref_rd(sa);
            chk("sram_rd", 32'(rd), 32'(exp));
            ob = exp;
         end
      end else if (rg == 1) begin
         chk("ppu_cnt", ppu_q.size(), 1);
         e = (ppu_q.size() > 0) ? ppu_q[0] : -1;
         chk("ppu_reg", 32'(e[11:9]), 32'(a[2:0]));
         chk("ppu_we", 32'(e[8]), 32'(w));
         if (w) begin
            chk("ppu_wdata", 32'(e[7:0]), 32'(d));
            ob = d;
         end else begin
            exp = ppu_val[a[2:0]];
            chk("ppu_rd", 32'(rd), 32'(exp));
            ob = exp;
         end
      end else begin
         idx = int'(a[4:0]);
         if (w) begin
            chk("io_cnt", io_q.size(), 1);
            e = (io_q.size() > 0) ? io_q[0] : -1;
            chk("io_index", 32'(e[12:8]), idx);
            chk("io_wdata", 32'(e[7:0]), 32'(d));
            ob = d;
         end else begin
            chk("io_rd_nostrobe", io_q.size(), 0);
            exp = (io_act[idx] & io_regs[idx]) | (~io_act[idx] & ob);
            chk("io_rd", 32'(rd), 32'(exp));
            ob = exp;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic [15:0] a;
      int got, first, p, rg;
      bit seen;
      reset = 1'b1;
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      bus_fp.req = '0; bus_fp.we = '0; bus_fp.addr = '0; bus_fp.wdata = '0;
      for (int i = 0; i < 32; i++) begin
         io_regs[i] = 8'($urandom);
         io_act[i] = 8'($urandom);
      end
      io_regs[22] = 8'h01;
      io_act[22] = 8'h1F;
      io_act[24] = 8'h00;
      for (int i = 0; i < (1 << 20); i++) dev_mem[i] = pat(i);
      for (int i = 0; i < 8; i++) ppu_val[i] = 8'($urandom);
      ppu_val[2] = 8'h9F;
      ob = 8'h00;
      rr_next = 0;

      repeat (3) @(negedge cpu_clock);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_io_write", 32'(io_write), 0);
      chk("rst_ppu_sel", 32'(ppu_sel), 0);
      chk("rst_oe_n", 32'(sram_oe_n), 1);
      chk("rst_we_n", 32'(sram_we_n), 1);
      chk("rst_data_oe", 32'(sram_data_oe), 0);
      chk("rst_sram_addr", 32'(sram_addr), 0);
      reset = 1'b0;

      do_op(0, 1, 16'h0801, 8'hA5, rd);
      do_op(0, 0, 16'h0001, 8'h00, rd);
      chk("mirror_rd", 32'(rd), 32'hA5);
      do_op(0, 1, 16'h4000, 8'h40, rd);
      do_op(0, 0, 16'h4016, 8'h00, rd);
      chk("io_open_bus", 32'(rd), 32'h41);
      do_op(0, 1, 16'h2000, 8'h80, rd);
      do_op(0, 0, 16'h2002, 8'h00, rd);
      chk("ppu_status", 32'(rd), 32'h9F);
      dev_mem[20'h14000] = 8'h4C;
      ref_mem['h14000] = 8'h4C;
      do_op(1, 0, 16'h8000, 8'h00, rd);
      chk("cart_rd", 32'(rd), 32'h4C);

      // Both masters hold requests continuously on the rotating DUT
      @(negedge cpu_clock);
      for (int i = 0; i < 2; i++) begin
         bus.req[i] = 1'b1; bus.we[i] = 1'b1;
         bus.addr[i] = 16'h0100 + 16'(i); bus.wdata[i] = 8'h11 * 8'(i + 1);
      end
      got = 0;
      for (int k = 0; k < 200 && got < 6; k++) begin
         @(negedge cpu_clock);
         if (bus.ack != 2'b00) begin
            chk("rr_order", 32'(bus.ack), 32'(1 << rr_next));
            p = bus.ack[1] ? 1 : 0;
            ref_mem['h100 + p] = 8'h11 * 8'(p + 1);
            ob = 8'h11 * 8'(p + 1);
            rr_next = (p + 1) % 2;
            got++;
            if (got == 6) bus.req = '0;
         end
      end
      bus.req = '0;
      chk("rr_count", got, 6);

      for (int r = 0; r < 3; r++) begin
         @(negedge cpu_clock);
         for (int i = 0; i < 2; i++) begin
            bus_fp.req[i] = 1'b1; bus_fp.we[i] = 1'b1;
            bus_fp.addr[i] = 16'h4000 + 16'(i); bus_fp.wdata[i] = 8'(r);
         end
         got = 0;
         first = -1;
         for (int k = 0; k < 40 && got < 2; k++) begin
            @(negedge cpu_clock);
            for (int i = 0; i < 2; i++)
               if (bus_fp.ack[i]) begin
                  if (first < 0) first = i;
                  bus_fp.req[i] = 1'b0;
                  got++;
               end
         end
         bus_fp.req = '0;
         chk("fp_first", first, 0);
         chk("fp_count", got, 2);
      end

      for (int n = 0; n < 60; n++) begin
         rg = $urandom_range(0, 3);
         unique case (rg)
            0: a = 16'($urandom_range(0, 'h1FFF));
            1: a = 16'($urandom_range('h2000, 'h3FFF));
            2: a = 16'($urandom_range('h4000, 'h401F));
            default: a = 16'($urandom_range('h4020, 'hFFFF));
         endcase
         do_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), a,
               8'($urandom), rd);
      end

      // Reset while a cartridge read holds the SRAM strobe low
      @(negedge cpu_clock);
      bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.addr[0] = 16'h8000;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge cpu_clock);
         if (!sram_oe_n) seen = 1'b1;
      end
      chk("mid_strobe_seen", 32'(seen), 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_oe_n", 32'(sram_oe_n), 1);
      chk("mid_rst_we_n", 32'(sram_we_n), 1);
      chk("mid_rst_data_oe", 32'(sram_data_oe), 0);
      bus.req[0] = 1'b0;
      @(negedge cpu_clock);
      chk("mid_rst_ack", 32'(bus.ack), 0);
      reset = 1'b0;
      ob = 8'h00;
      rr_next = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge cpu_clock);
         chk("no_ack_after_rst", 32'(bus.ack), 0);
      end
      do_op(0, 0, 16'h4018, 8'h00, rd);
      chk("open_bus_clr", 32'(rd), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/nes_bus_controller.md
# nes_bus_controller

Parametrised, multi-master successor to the CPU memory interface. Arbitrates NUM_PORTS requesters (port 0 = CPU, port 1 = OAM DMA, spares for debug/loader) onto a single SRAM and the NES memory-mapped register space. Adds a request/acknowledge handshake, a configurable SRAM wait-state count, PPU register forwarding, I/O write strobes and a modelled open-bus latch. Sits between the CPU/DMA engines and the board SRAM pins; the top level owns the tristate.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting masters (1..4)
- ADDR_WIDTH, 16, master address width
- SRAM_ADDR_WIDTH, 20, SRAM address width
- SRAM_WAIT, 1, extra SRAM cycles beyond the first (0..7)
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins), 1 = rotating priority
- RAM_MIRROR_BITS, 11, internal-RAM address bits kept (2 KiB, mirrored)

Ports (single clock `cpu_clock`; `reset` is asynchronous, active-high):
- cpu_clock  in  1  clock
- reset  in  1  async active-high reset
- req  in  NUM_PORTS  per-port request, held until ack
- we  in  NUM_PORTS  per-port write enable (1 = write)
- addr  in  NUM_PORTS×ADDR_WIDTH  per-port address
- wdata  in  NUM_PORTS×8  per-port write data
- ack  out  NUM_PORTS  one-cycle completion pulse
- rdata  out  8  read data, valid in the ack cycle
- io_regs  in  32×8  values for 0x4000–0x401F
- io_regs_active  in  32×8  driven-bit mask per register (0 bits read from open bus)
- io_write  out  1  write strobe to 0x4000–0x401F
- io_index  out  5  register index for io_write
- io_wdata  out  8  data for io_write
- ppu_sel  out  1  PPU register access strobe
- ppu_we  out  1  PPU access is a write
- ppu_reg  out  3  PPU register (addr[2:0])
- ppu_wdata  out  8  PPU write data
- ppu_rdata  in  8  PPU read data, valid the cycle after ppu_sel
- mapper_input_address  out  ADDR_WIDTH  granted address to mapper
- mapper_output_address  in  SRAM_ADDR_WIDTH  mapped SRAM address (combinational)
- sram_oe_n, sram_we_n  out  1  active-low strobes
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM address
- sram_wdata  out  8  SRAM write data
- sram_data_oe  out  1  top level drives sram_wdata onto pins when 1
- sram_rdata  in  8  SRAM pin data

## Operation
- FSM: IDLE → GRANT → (SRAM_ACC | REG_ACC) → DONE → IDLE.
- IDLE: if any req, pick winner (fixed or rotating from last grantee+1), latch addr/we/wdata into grant registers; → GRANT.
- GRANT: decode latched address; 0x0000–0x1FFF → SRAM_ACC with sram_addr = zero-extended addr[RAM_MIRROR_BITS-1:0]; 0x2000–0x3FFF → REG_ACC (PPU); 0x4000–0x401F → REG_ACC (I/O); ≥0x4020 → SRAM_ACC with sram_addr = mapper_output_address.
- SRAM_ACC: strobe low for SRAM_WAIT+1 cycles; write: sram_we_n low, sram_data_oe high; read: sram_oe_n low, sram_rdata captured on the final cycle.
- REG_ACC (one cycle): PPU — ppu_sel pulses; I/O write — io_write pulses; I/O read — result = (active & io_regs[i]) | (~active & open_bus).
- DONE: ack[grantee] high one cycle, rdata valid (PPU read uses ppu_rdata); open_bus ← read result or write data; → IDLE.
- Writes to 0x4018–0x401F still pulse io_write; consumers ignore them.

## Timing
- Reset values: ack 0, rdata 0x00, io_write 0, ppu_sel 0, sram_oe_n 1, sram_we_n 1, sram_data_oe 0, sram_addr 0, open_bus 0x00, rotation pointer 0, FSM IDLE.
- Latency req→ack: SRAM 4+SRAM_WAIT cycles; register 4 cycles. Back-to-back throughput: one transaction per latency plus one IDLE cycle.
- Master deasserting req before ack: transaction still completes; ack still issued.
- Simultaneous requests: exactly one grant; loser waits, no starvation in ROUND_ROBIN=1.
- Reset mid-access: strobes deassert immediately (asynchronous), no ack, open_bus cleared.
- Address wrap: internal RAM mirrors every 2^RAM_MIRROR_BITS bytes (0x0800 ≡ 0x0000 at default).

## Structure
- Package nes_bus_pkg: bus_state_t enum, region_t enum (REGION_RAM, REGION_PPU, REGION_IO, REGION_CART), region boundary constants 0x2000/0x4000/0x4020.
- One sub-module: nes_bus_arbiter (req vector + rotation pointer → one-hot grant, updates pointer on grant).

## Test plan
- CPU writes 0xA5 to 0x0801, then reads 0x0001 → SRAM write at 0x00001, read returns 0xA5, ack 4+SRAM_WAIT cycles after each req.
- Read 0x4016 with io_regs[22]=0x01, active=0x1F, open_bus=0x40 → rdata 0x41.
- Ports 0 and 1 request same cycle, ROUND_ROBIN=1, three rounds each → grants alternate 0,1,0,1…; ROUND_ROBIN=0 → port 0 served first every round.
- Write 0x80 to 0x2000, read 0x2002 with ppu_rdata=0x9F → ppu_sel pulses with ppu_reg 0 then 2, ppu_we 1 then 0, rdata 0x9F.
- Read 0x8000 with mapper_output_address=0x14000, sram_rdata=0x4C → sram_addr 0x14000, rdata 0x4C.
- Assert reset during SRAM_ACC → sram_oe_n/sram_we_n go 1 same cycle, no ack, later read of unmapped 0x4018 returns 0x00.
